multicycle_ctrl: RTL

- Main control FSM for the multi-cycle RV32I core. Sequences one shared ALU and one shared memory port through FETCH/DECODE/EXEC/MEM/WB.
- Drives the 2-bit select lines of the operand, writeback and PC-source 4:1 muxes, plus all register/memory enables.
- Adds a memory-wait timeout (trap on a hung bus) and a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences the shared ALU and
// memory port, with a memory-wait timeout trap and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       wb_sel,
  output logic             reg_we,
  output logic             trap,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             timeout;

  assign instret = instret_q;
  assign timeout = (wcnt_q == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      wcnt_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    wb_sel     = 2'b00;
    reg_we     = 1'b0;
    trap       = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end

      S_DECODE: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
          OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_d = S_EXEC;
          default:                           state_d = S_TRAP;
        endcase
      end

      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_src_a = 2'b01;
            state_d   = S_WB;
          end
          OP_I: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            state_d   = S_MEM;
          end
          OP_LUI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = S_WB;
          end
          OP_AUIPC: begin
            alu_src_a = 2'b11;
            alu_src_b = 2'b01;
            state_d   = S_WB;
          end
          OP_BRANCH: begin
            alu_src_a  = 2'b01;
            pc_sel     = 2'b01;
            pc_we      = branch_taken;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JAL: begin
            pc_sel     = 2'b01;
            pc_we      = 1'b1;
            wb_sel     = 2'b10;
            reg_we     = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JALR: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b01;
            pc_sel     = 2'b10;
            pc_we      = 1'b1;
            wb_sel     = 2'b10;
            reg_we     = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          // opcode changed under us after DECODE: treat as illegal
          default: state_d = S_TRAP;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end

      S_WB: begin
        reg_we     = 1'b1;
        wb_sel     = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_TRAP: begin
        trap    = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = 2'b11;
        state_d = S_FETCH;
      end

      default: state_d = S_RST;
    endcase

    instret_d = instr_done ? instret_q + CNT_W'(1) : instret_q;
  end

endmodule
